// File: rtl/regset_wb_arbiter.sv
// Write-back merger for the 32x32 register set: two buffered producer channels
// (ALU, memory load) share one write port round-robin and drive a pending-write scoreboard.
module regset_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_addr,
    input  logic [DW-1:0]     alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data,
    output logic [DW-1:0]     D,
    output logic [AW-1:0]     A_D,
    output logic              write_enable,
    output logic [2**AW-1:0]  pending
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NR = 2**AW;

    // Channel index 0 is the ALU, 1 is the memory-load channel.
    logic [1:0]                in_valid;
    logic [1:0][AW-1:0]        in_addr;
    logic [1:0][DW-1:0]        in_data;
    logic [1:0]                ready_int;
    logic [1:0]                nonempty;
    logic [1:0]                grant;
    logic [1:0][AW-1:0]        head_addr;
    logic [1:0][DW-1:0]        head_data;
    logic [1:0][NR-1:0]        chan_pend;

    assign in_valid  = {mem_valid, alu_valid};
    assign in_addr   = {mem_addr, alu_addr};
    assign in_data   = {mem_data, alu_data};
    assign alu_ready = ready_int[0];
    assign mem_ready = ready_int[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [AW-1:0]    addr_q [DEPTH];
            logic [DW-1:0]    data_q [DEPTH];
            logic [DEPTH-1:0] valid_reg;
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic             full;
            logic             push;
            logic             pop;
            logic [NR-1:0]    pend_local;

            // Per-slot valid bits make full/empty a single lookup at each pointer.
            assign full          = valid_reg[wr_ptr_reg];
            assign nonempty[gi]  = valid_reg[rd_ptr_reg];
            assign ready_int[gi] = RES && !full;
            // Writes to x0 complete the handshake but are dropped here.
            assign push          = in_valid[gi] && ready_int[gi] && (in_addr[gi] != '0);
            assign pop           = grant[gi];
            assign head_addr[gi] = addr_q[rd_ptr_reg];
            assign head_data[gi] = data_q[rd_ptr_reg];

            always_ff @(posedge CLK) begin
                if (!RES) begin
                    valid_reg  <= '0;
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push) begin
                        addr_q[wr_ptr_reg]    <= in_addr[gi];
                        data_q[wr_ptr_reg]    <= in_data[gi];
                        valid_reg[wr_ptr_reg] <= 1'b1;
                        wr_ptr_reg            <= wr_ptr_reg + PW'(1);
                    end
                    if (pop) begin
                        valid_reg[rd_ptr_reg] <= 1'b0;
                        rd_ptr_reg            <= rd_ptr_reg + PW'(1);
                    end
                end
            end

            always_comb begin
                pend_local = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (valid_reg[j]) begin
                        pend_local[addr_q[j]] = 1'b1;
                    end
                end
            end

            assign chan_pend[gi] = pend_local;
        end
    endgenerate

    // last_grant_reg = 0 means ALU won the last tie, so memory wins the next one.
    logic last_grant_reg;
    logic last_grant_next;

    always_comb begin
        grant           = 2'b00;
        last_grant_next = last_grant_reg;
        case (nonempty)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (last_grant_reg) begin
                    grant           = 2'b01;
                    last_grant_next = 1'b0;
                end else begin
                    grant           = 2'b10;
                    last_grant_next = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            last_grant_reg <= 1'b0;
            D              <= '0;
            A_D            <= '0;
            write_enable   <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
            if (|grant) begin
                D            <= head_data[grant[1]];
                A_D          <= head_addr[grant[1]];
                write_enable <= 1'b1;
            end else begin
                write_enable <= 1'b0;
            end
        end
    end

    always_comb begin
        pending = chan_pend[0] | chan_pend[1];
        if (write_enable) begin
            pending[A_D] = 1'b1;
        end
        pending[0] = 1'b0;
    end
endmodule

// File: tb/tb_regset_wb_arbiter.sv
// Directed bench for regset_wb_arbiter: handshake, round-robin, backpressure,
// x0 filtering, mid-stream reset and same-register races.
module tb_regset_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RES;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr;
    logic [DW-1:0] alu_data, mem_data;
    logic [DW-1:0] D;
    logic [AW-1:0] A_D;
    logic          write_enable;
    logic [31:0]   pending;

    int passed = 0;
    int total  = 0;

    regset_wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RES(RES),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .D(D), .A_D(A_D), .write_enable(write_enable), .pending(pending)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_we"}, write_enable, we);
        chk({tag, "_ad"}, A_D, a);
        chk({tag, "_d"}, D, d);
    endtask

    task automatic push2(input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic [AW-1:0] ma, input logic [DW-1:0] md);
        alu_valid = 1'b1; alu_addr = aa; alu_data = ad;
        mem_valid = 1'b1; mem_addr = ma; mem_data = md;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
    endtask

    logic [AW-1:0] exp_a [8] = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4, 5'd13};
    logic [AW-1:0] got_a [8];
    logic [DW-1:0] got_d [8];

    initial begin
        int ai, mi, nw, seen_we;
        logic fa, fm, saw_full;
        RES = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;

        // 1. reset then single ALU write
        step(); step();
        chk_port("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_pend", pending, 32'd0);
        chk("rst_alu_rdy", alu_ready, 1'b0);
        chk("rst_mem_rdy", mem_ready, 1'b0);
        RES = 1'b1;
        #1;
        chk("alu_rdy", alu_ready, 1'b1);
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("t1_we_k", write_enable, 1'b0);
        chk("t1_pend_k", pending, 32'h20);
        step();
        chk_port("t1_wr", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("t1_pend_wr", pending, 32'h20);
        step();
        chk_port("t1_idle", 1'b0, 5'd5, 32'hDEADBEEF);
        chk("t1_pend_end", pending, 32'd0);

        // 2. round-robin ties right after reset: mem, then alu, then mem
        RES = 1'b0; step(); RES = 1'b1;
        push2(5'd3, 32'h11, 5'd4, 32'h22);
        chk("t2_pend", pending, 32'h18);
        step(); chk_port("t2a_first", 1'b1, 5'd4, 32'h22);
        step(); chk_port("t2a_second", 1'b1, 5'd3, 32'h11);
        step(); chk("t2a_idle", write_enable, 1'b0);
        push2(5'd3, 32'h33, 5'd4, 32'h44);
        step(); chk_port("t2b_first", 1'b1, 5'd3, 32'h33);
        step(); chk_port("t2b_second", 1'b1, 5'd4, 32'h44);
        step(); chk("t2b_idle", write_enable, 1'b0);
        push2(5'd8, 32'h55, 5'd9, 32'h66);
        step(); chk_port("t2c_first", 1'b1, 5'd9, 32'h66);
        step(); chk_port("t2c_second", 1'b1, 5'd8, 32'h55);
        step(); chk("t2c_idle", write_enable, 1'b0);

        // 6. same-register race with the pointer favouring alu
        push2(5'd7, 32'hA, 5'd7, 32'hB);
        chk("t6_pend_k", pending, 32'h80);
        step(); chk_port("t6_first", 1'b1, 5'd7, 32'hA);
        chk("t6_pend_1", pending, 32'h80);
        step(); chk_port("t6_second", 1'b1, 5'd7, 32'hB);
        chk("t6_pend_2", pending, 32'h80);
        step(); chk("t6_we_end", write_enable, 1'b0);
        chk("t6_pend_end", pending, 32'd0);

        // 4. x0 filter
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        chk("t4_rdy", alu_ready, 1'b1);
        step();
        alu_valid = 1'b0;
        chk("t4_we_k", write_enable, 1'b0);
        chk("t4_pend_k", pending, 32'd0);
        step();
        chk_port("t4_idle", 1'b0, 5'd7, 32'hB);
        chk("t4_pend", pending, 32'd0);

        // 3. backpressure: both channels stream four writes each
        ai = 0; mi = 0; nw = 0; saw_full = 1'b0;
        for (int c = 0; c < 14; c++) begin
            alu_valid = (ai < 4); alu_addr = AW'(10 + ai); alu_data = 32'h200 + ai;
            mem_valid = (mi < 4); mem_addr = AW'(1 + mi);  mem_data = 32'h101 + mi;
            #1;
            fa = alu_valid && alu_ready;
            fm = mem_valid && mem_ready;
            if (mem_valid && !mem_ready) saw_full = 1'b1;
            step();
            if (fa) ai++;
            if (fm) mi++;
            if (write_enable) begin
                if (nw < 8) begin
                    got_a[nw] = A_D;
                    got_d[nw] = D;
                end
                nw++;
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("t3_mem_full", saw_full, 1'b1);
        chk("t3_alu_sent", ai, 4);
        chk("t3_mem_sent", mi, 4);
        chk("t3_nwrites", nw, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_addr%0d", k), got_a[k], exp_a[k]);
            chk($sformatf("t3_data%0d", k), got_d[k],
                (exp_a[k] >= 5'd10) ? 32'h200 + exp_a[k] - 10 : 32'h100 + exp_a[k]);
        end
        chk("t3_pend_end", pending, 32'd0);

        // 5. reset mid-stream
        push2(5'd20, 32'h20, 5'd21, 32'h21);
        alu_valid = 1'b1; alu_addr = 5'd22; alu_data = 32'h22;
        mem_valid = 1'b1; mem_addr = 5'd23; mem_data = 32'h23;
        step();
        alu_addr = 5'd25; mem_addr = 5'd26;
        RES = 1'b0;
        #1;
        chk("t5_alu_rdy_lo", alu_ready, 1'b0);
        chk("t5_mem_rdy_lo", mem_ready, 1'b0);
        step();
        chk_port("t5_rst", 1'b0, 5'd0, 32'd0);
        chk("t5_pend", pending, 32'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        RES = 1'b1;
        #1;
        chk("t5_alu_rdy_hi", alu_ready, 1'b1);
        seen_we = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (write_enable) seen_we++;
        end
        chk("t5_no_stale", seen_we, 0);
        chk("t5_pend_end", pending, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regset_wb_arbiter.md
Name: regset_wb_arbiter

Overview:
Write-back side driver for the 32x32 register set. It accepts result writes from two independent producers: the ALU channel and the memory-load channel. Each producer has a valid/ready handshake. Writes are buffered per channel and merged round-robin onto the register set's single write port (D, A_D, write_enable). It also exports a pending-write scoreboard so the issue stage can stall on read-after-write hazards.

Parameters:
DEPTH, 2, entries per channel FIFO (power of two, >=2)
AW, 5, register address width
DW, 32, data width

Ports:
CLK  input  1  clock; all state updates on rising edge
RES  input  1  synchronous reset, active-low
alu_valid  input  1  ALU write request
alu_ready  output  1  ALU channel can accept
alu_addr  input  AW  destination register
alu_data  input  DW  result value
mem_valid  input  1  load write request
mem_ready  output  1  load channel can accept
mem_addr  input  AW  destination register
mem_data  input  DW  load value
D  output  DW  write data to register set
A_D  output  AW  write address to register set
write_enable  output  1  write strobe to register set
pending  output  2**AW  bit i = write to register i in flight

Behaviour:
- Reset (RES low at a rising edge): both FIFOs are emptied and contents discarded. D=0, A_D=0, write_enable=0, pending=0. Round-robin pointer is set so that mem wins the first tie. alu_ready and mem_ready are 0 during any cycle in which RES is low.
- Handshake: a transfer occurs at an edge where valid && ready.
  - ready = !full of that channel's FIFO. ready is independent of valid.
  - A full FIFO does not accept a push even if it pops at the same edge.
  - valid is expected to stay asserted with stable addr/data until the transfer occurs. The block does not check this.
- x0 filter: a transfer with addr==0 is accepted (handshake completes) but is not enqueued. It never reaches the port.
- FIFO: DEPTH entries of {addr, data} per channel. Order is preserved within a channel. Pointers wrap modulo DEPTH. A simultaneous push and pop on a non-full FIFO is legal and leaves the count unchanged.
- Arbitration, evaluated every cycle on the FIFO heads:
  - Only one channel non-empty: pop that head.
  - Both non-empty: pop the channel not granted last, then flip the pointer to the granted channel.
  - Neither non-empty: no pop, pointer unchanged.
- Output register: at the pop edge, D/A_D are loaded from the popped head and write_enable=1. Without a pop, write_enable=0 and D/A_D hold their previous values.
- At most one write per cycle.
- Latency, no contention:
  - Transfer at edge k.
  - Pop at edge k+1.
  - write_enable high in cycle k+1..k+2.
  - Register set captures at edge k+2.
- Throughput: one write per cycle sustained, total across both channels.
- No ordering is guaranteed between channels. When both write the same register, the later pop wins at the register set.
- pending: combinational from state. Bit i=1 if any valid FIFO entry in either channel has addr==i, or if write_enable==1 && A_D==i. Bit 0 is always 0. A bit clears in the cycle after the register set captures the write.
- Reset mid-operation: queued writes are lost. write_enable drops to 0 in the cycle after the reset edge. pending clears in the same cycle.

Test Plan:
1. Reset then single write: RES low 2 cycles, then alu_valid=1, addr=5, data=0xDEADBEEF for one accepted cycle -> write_enable=1, A_D=5, D=0xDEADBEEF exactly 1 cycle after acceptance, for 1 cycle. pending[5]=1 from acceptance until write_enable falls.
2. Round-robin tie: both channels push at the same edge (alu addr=3, data=0x11; mem addr=4, data=0x22) right after reset -> mem (A_D=4) is written first, then alu (A_D=3) on the next cycle. Repeat with fresh pushes -> alu first.
3. Backpressure/full: mem channel pushes every cycle (addr 1..4) while alu holds a continuous stream -> mem_ready drops to 0 when DEPTH=2 entries are queued. All four mem writes appear in order 1,2,3,4 interleaved with alu. None are lost or duplicated.
4. x0 filter: alu writes addr=0, data=0xFFFFFFFF -> handshake completes, write_enable stays 0, pending stays 0.
5. Reset mid-stream: queue 2 alu and 2 mem entries, then drive RES low for one edge -> write_enable=0 in the next cycle, pending=0, ready=0 while RES is low. No queued write appears after RES returns high.
6. Same-register race: alu addr=7, data=0xA and mem addr=7, data=0xB, pushed at the same edge after the pointer favours alu -> port sequence is 0xA then 0xB. pending[7] stays 1 until the second write_enable cycle ends.
